// File: rtl/spi_rx_pkg.sv
// Shared constants and types for the SPI receive front end.
// Holds the frame geometry (16-bit frame = wr bit, 7-bit address, 8-bit
// data), the bit counter width and saturation value, and the receive FSM
// state encoding.
package spi_rx_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_W      = 5;

    // The bit counter stops here, so any frame longer than 16 bits stays
    // distinguishable from a good one.
    localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;
    localparam logic [CNT_W-1:0] CNT_GOOD = 5'd16;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Multi-flop synchronizer with one history flop, for one asynchronous
// SPI input.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   din       - asynchronous input
//   sync      - synchronized value (last stage of the chain)
//   prev      - sync delayed by one clk, used for edge detection
// Parameters:
//   SYNC_STAGES - chain depth (minimum 2)
//   RESET_VAL   - value every flop takes on reset
module spi_rx_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic prev
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_rx_frontend.sv
// SPI (mode 0) receive front end. Synchronizes SCLK/COPI/nCS into clk,
// deserializes 16-bit MSB-first frames and hands each complete frame to a
// register block through a one-entry valid/ready holding slot.
// Configuration macro: SPI_RX_ADDR_FILTER_EN - when defined, frames that
// are reads (wr == 0) or address above MAX_ADDR are rejected as errors.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   SCLK, COPI, nCS   - asynchronous SPI inputs
//   frame_valid       - a frame is held in the slot
//   frame_ready       - register block takes the held frame this cycle
//   frame_wr/addr/data- payload of the held frame (bit 15, 14:8, 7:0)
//   frame_err         - 1-cycle pulse: malformed/filtered frame discarded
//   frame_ovf         - 1-cycle pulse: good frame dropped, slot was full
//   fsm_state         - current receive FSM state (observability)
// Handshake: a transfer happens on each clk edge where frame_valid and
// frame_ready are both high; while frame_valid is high and no transfer
// has happened, the payload is held stable.
module spi_rx_frontend
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SCLK,
    input  logic              COPI,
    input  logic              nCS,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              frame_wr,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              frame_ovf,
    output state_t            fsm_state
);

    // ---------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------
    logic sclk_sync, sclk_prev;
    logic copi_sync, copi_prev_unused;
    logic ncs_sync,  ncs_prev;

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(SCLK), .sync(sclk_sync), .prev(sclk_prev)
    );

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .din(COPI), .sync(copi_sync), .prev(copi_prev_unused)
    );

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(nCS), .sync(ncs_sync), .prev(ncs_prev)
    );

    logic sclk_rise, ncs_rise, ncs_fall;
    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign ncs_rise  = ncs_sync  & ~ncs_prev;
    assign ncs_fall  = ~ncs_sync &  ncs_prev;

    // ---------------------------------------------------------------
    // Post-reset settle: the nCS chain resets to 1, so a low nCS at reset
    // release only shows up at the chain output a few cycles later. The
    // FSM may not leave WAIT_IDLE until the chain holds real samples,
    // otherwise that reset-value 1 would look like an idle bus and the
    // tail of an interrupted transaction would be decoded.
    // ---------------------------------------------------------------
    localparam logic [7:0] SETTLE_CYCLES = 8'(SYNC_STAGES + 1);

    logic [7:0] settle_cnt;
    logic       settled;

    assign settled = (settle_cnt == SETTLE_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (!settled) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

    // ---------------------------------------------------------------
    // Frame acceptance rule
    // ---------------------------------------------------------------
    logic [FRAME_BITS-1:0] shifter;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  frame_ok;

`ifdef SPI_RX_ADDR_FILTER_EN
    localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);
    assign frame_ok = (bit_cnt == CNT_GOOD) && shifter[15] &&
                      (shifter[14:8] <= MAX_ADDR_L);
`else
    localparam logic [ADDR_W-1:0] MAX_ADDR_L = ADDR_W'(MAX_ADDR);
    logic unused_cfg;
    assign unused_cfg = ^MAX_ADDR_L;
    assign frame_ok   = (bit_cnt == CNT_GOOD);
`endif

    // ---------------------------------------------------------------
    // Receive FSM
    // ---------------------------------------------------------------
    state_t state, state_next;
    logic   start_frame, shift_bit, commit_next, err_next;

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_bit   = 1'b0;
        commit_next = 1'b0;
        err_next    = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (settled && ncs_sync) state_next = IDLE;
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_next  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next  = IDLE;
                    commit_next = frame_ok;
                    err_next    = ~frame_ok;
                end else if (sclk_rise) begin
                    shift_bit = 1'b1;
                end
            end
            default: state_next = WAIT_IDLE;
        endcase
    end

    assign fsm_state = state;

    // ---------------------------------------------------------------
    // Shifter, bit counter and the registered commit/err events
    // ---------------------------------------------------------------
    logic commit_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shifter   <= '0;
            bit_cnt   <= '0;
            commit_q  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            commit_q  <= commit_next;
            frame_err <= err_next;
            if (start_frame) begin
                shifter <= '0;
                bit_cnt <= '0;
            end else if (shift_bit) begin
                shifter <= {shifter[FRAME_BITS-2:0], copi_sync};
                if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Holding slot. The shifter is only cleared on the next nCS falling
    // edge, which cannot be seen before the edge that loads the slot, so
    // it still holds the committed frame here.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_wr    <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
            frame_ovf   <= 1'b0;
        end else begin
            frame_ovf <= 1'b0;
            if (commit_q) begin
                if (!frame_valid || frame_ready) begin
                    frame_valid <= 1'b1;
                    frame_wr    <= shifter[15];
                    frame_addr  <= shifter[14:8];
                    frame_data  <= shifter[7:0];
                end else begin
                    frame_ovf <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Directed + randomized bench for spi_rx_frontend. Two instances run side
// by side on the same SPI bus: SYNC_STAGES = 2 (main checks) and
// SYNC_STAGES = 3 (latency comparison). Honors SPI_RX_ADDR_FILTER_EN.
module tb_spi_rx_frontend;
    import spi_rx_pkg::*;

    localparam int MAX_ADDR = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       SCLK = 1'b0, COPI = 1'b0, nCS = 1'b1;
    logic       frame_ready = 1'b1;
    logic       frame_valid, frame_wr, frame_err, frame_ovf;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    state_t     st2;

    logic       v3, wr3, err3, ovf3;
    logic [6:0] addr3;
    logic [7:0] data3;
    state_t     st3;

    spi_rx_frontend #(.SYNC_STAGES(2), .MAX_ADDR(MAX_ADDR)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_wr(frame_wr), .frame_addr(frame_addr), .frame_data(frame_data),
        .frame_err(frame_err), .frame_ovf(frame_ovf), .fsm_state(st2)
    );

    spi_rx_frontend #(.SYNC_STAGES(3), .MAX_ADDR(MAX_ADDR)) dut3 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .COPI(COPI), .nCS(nCS),
        .frame_valid(v3), .frame_ready(1'b1),
        .frame_wr(wr3), .frame_addr(addr3), .frame_data(data3),
        .frame_err(err3), .frame_ovf(ovf3), .fsm_state(st3)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int err_cnt = 0, ovf_cnt = 0, valid_cycles = 0;
    int exp_err = 0, exp_ovf = 0;

    // Observe the main instance just after the negedge, once the stimulus
    // for this cycle has been applied.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (frame_err)   err_cnt++;
            if (frame_ovf)   ovf_cnt++;
            if (frame_valid) valid_cycles++;
            if (frame_valid && frame_ready)
                got_q.push_back({frame_wr, frame_addr, frame_data});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference rule: a frame is delivered iff it has exactly 16 bits and,
    // with filtering built in, is a write to an address <= MAX_ADDR.
    function automatic bit frame_good(input logic [15:0] v, input int n);
        if (n != 16) return 1'b0;
`ifdef SPI_RX_ADDR_FILTER_EN
        if (v[15] == 1'b0 || int'(v[14:8]) > MAX_ADDR) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic void model(input logic [15:0] v, input int n);
        if (frame_good(v, n)) exp_q.push_back(v);
        else                  exp_err++;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_frames"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_payload"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, "_err"}, err_cnt, exp_err);
        check({tag, "_ovf"}, ovf_cnt, exp_ovf);
    endtask

    // ---------------- drivers (SCLK = clk/8) ----------------
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            COPI = v[i];
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int n);
        nCS = 1'b0;
        repeat (8) @(negedge clk);
        shift_bits(v, n);
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        COPI = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat2, lat3, vc0, n;
        logic [15:0] v;

        // Reset state
        repeat (4) @(negedge clk);
        #1;
        check("rst_valid", frame_valid, 0);
        check("rst_err",   frame_err,   0);
        check("rst_ovf",   frame_ovf,   0);
        check("rst_pay",   {frame_wr, frame_addr, frame_data}, 0);
        check("rst_state", st2, WAIT_IDLE);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("idle_state", st2, IDLE);

        // Basic frame 0x8455 with latency measurement on both instances
        vc0 = valid_cycles;
        nCS = 1'b0;
        repeat (8) @(negedge clk);
        shift_bits(32'h8455, 16);
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        lat2 = 0;
        lat3 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (lat2 == 0 && frame_valid) lat2 = c;
            if (lat3 == 0 && v3)          lat3 = c;
        end
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("latency_s2", lat2, 4);
        check("latency_s3", lat3, 5);
        check("basic_valid_cycles", valid_cycles - vc0, 1);
        check("basic_wr3_addr3_data3", {wr3, addr3, data3}, 16'h8455);
        model(16'h8455, 16);
        compare_all("basic");

        // Short and long frames
        vc0 = valid_cycles;
        send_frame(32'h7fff, 15);
        model(16'h7fff, 15);
        check("short_err", err_cnt, exp_err);
        send_frame(32'h1_0455, 17);
        model(16'h0455, 17);
        check("long_err", err_cnt, exp_err);
        check("badlen_no_valid", valid_cycles - vc0, 0);
        compare_all("badlen");

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            v = 16'($urandom_range(0, 16'hffff));
            if (k < 3) v = {1'b1, 7'($urandom_range(0, MAX_ADDR)), v[7:0]};
            n = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
            send_frame({15'($urandom), v[15:0]} >> (16 - n) << (16 - n) >> (16 - n) | 32'(v) & ((32'd1 << n) - 1), n);
            model((n == 17) ? 16'(v) : v, n);
        end
        compare_all("random");

        // Back-pressure: second frame overflows, first is held
        frame_ready = 1'b0;
        send_frame(32'h8011, 16);
        send_frame(32'h8122, 16);
        exp_ovf++;
        check("bp_valid_held", frame_valid, 1);
        check("bp_payload_held", {frame_wr, frame_addr, frame_data}, 16'h8011);
        check("bp_ovf", ovf_cnt, exp_ovf);
        check("bp_no_accept", got_q.size(), 0);
        frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("bp_valid_drop", frame_valid, 0);
        exp_q.push_back(16'h8011);
        compare_all("backpressure");

        // Reset in the middle of a frame
        nCS = 1'b0;
        repeat (8) @(negedge clk);
        shift_bits(32'h00a5, 6);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("midrst_valid", frame_valid, 0);
        check("midrst_pay", {frame_wr, frame_addr, frame_data}, 0);
        check("midrst_state", st2, WAIT_IDLE);
        rst = 1'b0;
        shift_bits(32'h00a5, 10);
        repeat (4) @(negedge clk);
        nCS = 1'b1;
        repeat (14) @(negedge clk);
        check("midrst_state_after", st2, IDLE);
        send_frame(32'h8233, 16);
        model(16'h8233, 16);
        compare_all("midreset");

        // Read / out-of-range frame, filter-dependent
        send_frame(32'h0703, 16);
        model(16'h0703, 16);
        compare_all("filter");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_frontend.md
SPI_RX_FRONTEND -- requirements
Module: spi_rx_frontend

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of each input synchronizer (minimum 2).
REQ-002 SHALL have parameter MAX_ADDR, default 4, meaning the highest register address accepted when filtering is compiled in.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 SHALL have port SCLK, input, 1, meaning the asynchronous SPI serial clock (mode 0).
REQ-006 SHALL have port COPI, input, 1, meaning the asynchronous SPI serial data, MSB first.
REQ-007 SHALL have port nCS, input, 1, meaning the asynchronous SPI chip select, active-low.
REQ-008 SHALL have port frame_valid, output, 1, meaning a decoded frame is held for the register block.
REQ-009 SHALL have port frame_ready, input, 1, meaning the register block accepts the held frame this cycle.
REQ-010 SHALL have port frame_wr, output, 1, meaning frame bit 15 (1 = write).
REQ-011 SHALL have port frame_addr, output, 7, meaning frame bits 14:8.
REQ-012 SHALL have port frame_data, output, 8, meaning frame bits 7:0.
REQ-013 SHALL have port frame_err, output, 1, meaning a one-cycle pulse when a frame is discarded as malformed.
REQ-014 SHALL have port frame_ovf, output, 1, meaning a one-cycle pulse when a good frame is dropped because the holding slot is full.

Function
REQ-015 SHALL pass SCLK, COPI and nCS each through a SYNC_STAGES flip-flop synchronizer, plus one history flop on SCLK and nCS for edge detection.
REQ-016 SHALL implement FSM states WAIT_IDLE, IDLE and SHIFT; reset SHALL enter WAIT_IDLE.
REQ-017 SHALL move WAIT_IDLE to IDLE on the first cycle the synchronized nCS is high.
REQ-018 SHALL move IDLE to SHIFT on the synchronized nCS falling edge, clearing the 16-bit shifter and the 5-bit bit counter.
REQ-019 In SHIFT, SHALL shift synchronized COPI into the shifter LSB on each synchronized SCLK rising edge; the counter SHALL saturate at 17.
REQ-020 SHALL ignore SCLK edges outside SHIFT.
REQ-021 On the synchronized nCS rising edge in SHIFT, SHALL commit the frame if count == 16, otherwise pulse frame_err for 1 cycle; the FSM SHALL return to IDLE either way.
REQ-022 On commit, SHALL assert frame_valid on the next clk edge and present wr/addr/data from the shifter.
REQ-023 SHALL hold frame_valid and the payload stable until a cycle with frame_valid && frame_ready, then deassert frame_valid on the following edge.
REQ-024 If a commit coincides with frame_valid && frame_ready, SHALL load the new frame and keep frame_valid high.
REQ-025 If a commit coincides with frame_valid && !frame_ready, SHALL keep the old frame, discard the new one and pulse frame_ovf for 1 cycle.
REQ-026 Latency SHALL be exactly SYNC_STAGES+2 clk cycles from the first clk edge sampling nCS high to frame_valid high.

Reset
REQ-027 On rst, SHALL clear frame_valid, frame_wr, frame_addr, frame_data, frame_err, frame_ovf, the shifter, the counter and all synchronizer and history flops to 0; the nCS flops SHALL reset to 1.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, and SHALL NOT produce an err pulse.
REQ-029 If nCS is low when rst deasserts, SHALL stay in WAIT_IDLE and ignore that whole transaction.

Configuration
REQ-030 With SPI_RX_ADDR_FILTER_EN defined, a 16-bit frame with frame_wr == 0 or addr > MAX_ADDR SHALL be dropped with a frame_err pulse instead of being committed.
REQ-031 Without SPI_RX_ADDR_FILTER_EN, every 16-bit frame SHALL be committed regardless of wr bit or address.

Structure
REQ-032 Package spi_rx_pkg SHALL hold FRAME_BITS=16, ADDR_W=7, DATA_W=8 and the FSM state enum.
REQ-033 Sub-module spi_rx_sync (synchronizer plus history flop, SYNC_STAGES parameter) SHALL be instantiated once per SPI input.

Verification
REQ-034 Reset, nCS high, send 0x8455 at SCLK = clk/8 with frame_ready = 1 -> one frame_valid, wr = 1, addr = 0x04, data = 0x55, no err or ovf.
REQ-035 Send 15 bits, then 17 bits -> frame_err pulses once per frame, frame_valid stays 0.
REQ-036 Hold frame_ready = 0, send 0x8011 then 0x8122 -> 0x8011 is held, frame_ovf pulses once; raise ready -> 0x8011 is accepted, then valid drops.
REQ-037 Assert rst in the middle of a frame with nCS still low -> outputs are 0 and the remainder is ignored; the next full frame decodes correctly.
REQ-038 Send 0x0703 -> with SPI_RX_ADDR_FILTER_EN, frame_err pulses and there is no valid; without it, valid with wr = 0, addr = 0x07, data = 0x03.
REQ-039 Measure latency with SYNC_STAGES = 2 and 3 -> frame_valid rises 4 and 5 clk cycles after nCS is first sampled high.
